// File: rtl/mem_pkg.sv
// Shared constants for the simulation memory: default depth and the
// memory-mapped console / test-result addresses.
package mem_pkg;

    localparam int          MEM_WORDS_DEFAULT = 32768;
    localparam logic [31:0] CONSOLE_ADDR      = 32'h1000_0000;
    localparam logic [31:0] PASS_ADDR         = 32'h2000_0000;
    localparam logic [31:0] PASS_VALUE        = 32'd123456789;

    // Byte address with the in-word offset cleared; the low two bits
    // never take part in decoding.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem.sv
// Single-port word memory with a console output port and a sticky
// test-pass flag, answering one request every two cycles.
//
// Handshake: a request is taken on a rising edge where mem_valid=1 and
// mem_ready=0; mem_ready is then high for exactly one cycle, carrying read
// data for reads. The core keeps address/data/strobes stable until
// mem_ready; dropping mem_valid before that cancels the request.
module mem #(
    parameter int          MEM_WORDS    = mem_pkg::MEM_WORDS_DEFAULT,
    parameter logic [31:0] CONSOLE_ADDR = mem_pkg::CONSOLE_ADDR,
    parameter logic [31:0] PASS_ADDR    = mem_pkg::PASS_ADDR,
    parameter logic [31:0] PASS_VALUE   = mem_pkg::PASS_VALUE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        tests_passed
);

    import mem_pkg::*;

    localparam int          IDX_W       = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [31:0] MEM_WORDS_L = 32'(MEM_WORDS);

    // Storage is deliberately not reset so preloaded firmware survives.
    logic [31:0] sram [0:MEM_WORDS-1];

    logic             ready_q, ready_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             passed_q, passed_d;

    logic             accept;
    logic             is_read;
    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic [31:0]      word_addr;
    logic             unused_addr_bits;

    // Full 32-bit range compare so high addresses never alias into sram.
    assign word_addr        = word_align(mem_addr);
    assign in_range         = {2'b00, mem_addr[31:2]} < MEM_WORDS_L;
    assign idx              = mem_addr[IDX_W+1:2];
    assign accept           = mem_valid && !ready_q;
    assign is_read          = (mem_wstrb == 4'b0000);
    assign unused_addr_bits = ^mem_addr[1:0];

    // Next-state for the handshake, read data and pass flag.
    always_comb begin
        ready_d  = accept;
        rdata_d  = rdata_q;
        passed_d = passed_q;
        if (accept && is_read) begin
            rdata_d = in_range ? sram[idx] : 32'h0;
        end
        if (accept && !is_read && word_addr == PASS_ADDR && mem_wdata == PASS_VALUE) begin
            passed_d = 1'b1;
        end
    end

    // Control/result registers, cleared asynchronously by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ready_q  <= 1'b0;
            rdata_q  <= 32'h0;
            passed_q <= 1'b0;
        end else begin
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
            passed_q <= passed_d;
        end
    end

    // Byte-masked sram write; a request overlapping reset is dropped.
    always_ff @(posedge clock) begin
        if (accept && !reset && !is_read && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wstrb[b]) begin
                    sram[idx][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

`ifndef SYNTHESIS
    // Console character output for simulation only.
    always_ff @(posedge clock) begin
        if (accept && !reset && !is_read && word_addr == CONSOLE_ADDR) begin
            $write("%c", mem_wdata[7:0]);
        end
    end
`endif

    assign mem_ready    = ready_q;
    assign mem_rdata    = rdata_q;
    assign tests_passed = passed_q;

endmodule

// File: tb/tb_mem.sv
// Directed bench for mem: a word/byte-level memory model, an expected-data
// queue consumed on every mem_ready cycle, and literal spot checks.
module tb_mem;

    localparam int          MEM_WORDS  = 32768;
    localparam logic [31:0] CONS_A     = 32'h1000_0000;
    localparam logic [31:0] PASS_A     = 32'h2000_0000;
    localparam logic [31:0] PASS_V     = 32'd123456789;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        tests_passed;

    mem dut (
        .clock        (clock),
        .reset        (reset),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_rdata    (mem_rdata),
        .tests_passed (tests_passed)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    // ---------------- model & scoreboard ----------------
    typedef struct {
        bit          hold;   // write: read data must keep its old value
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_mem [int];
    bit          model_passed;
    logic [31:0] held_rdata;
    bit          scoreboard_on;
    int          n_checks;
    int          n_errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        int unsigned w;
        w = addr / 4;
        if (w >= MEM_WORDS) return 32'h0;
        if (!model_mem.exists(int'(w))) return 32'h0;
        return model_mem[int'(w)];
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wstrb);
        int unsigned w;
        logic [31:0] word;
        w = addr / 4;
        if (w < MEM_WORDS) begin
            word = model_read(addr);
            for (int b = 0; b < 4; b++)
                if (wstrb[b]) word[8*b +: 8] = wdata[8*b +: 8];
            model_mem[int'(w)] = word;
        end
        if ((addr & ~32'd3) == PASS_A && wdata == PASS_V) model_passed = 1'b1;
    endtask

    // Compare process: every cycle outside reset, read data must either hold
    // or, on a mem_ready cycle, match the next expected transaction.
    always @(negedge clock) begin
        if (scoreboard_on) begin
            if (reset) begin
                held_rdata = 32'h0;
            end else if (mem_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ready", {31'h0, mem_ready}, 32'h0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (!e.hold) held_rdata = e.data;
                    check("sb_rdata", mem_rdata, held_rdata);
                end
            end else begin
                check("sb_rdata_hold", mem_rdata, held_rdata);
            end
        end
    end

    // ---------------- driver ----------------
    // Called at a falling edge; returns at a falling edge.
    task automatic do_req(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, output logic [31:0] rd);
        exp_t e;
        if (wstrb == 4'b0) begin
            e.hold = 1'b0;
            e.data = model_read(addr);
        end else begin
            e.hold = 1'b1;
            e.data = 32'h0;
            model_write(addr, wdata, wstrb);
        end
        exp_q.push_back(e);
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        @(posedge clock); #1;
        check("ready_latency", {31'h0, mem_ready}, 32'h1);
        rd = mem_rdata;
        @(negedge clock);
        mem_valid = 1'b0;
        @(posedge clock); #1;
        check("ready_single", {31'h0, mem_ready}, 32'h0);
        check("tests_passed", {31'h0, tests_passed}, {31'h0, model_passed});
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_passed = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        held_rdata = 32'h0;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } vec_t;

    vec_t vecs [6] = '{
        '{32'h0000_0008, 32'hCAFEF00D, 4'b1111},
        '{32'h0000_0008, 32'h0000_0000, 4'b0000},
        '{32'h0000_000A, 32'h1234_5678, 4'b1000},
        '{32'h0000_0008, 32'h0000_0000, 4'b0000},
        '{32'h0001_FFFC, 32'h0BAD_C0DE, 4'b0011},
        '{32'h0001_FFFC, 32'h0000_0000, 4'b0000}
    };

    initial begin
        logic [31:0] rd;
        n_checks = 0;
        n_errors = 0;
        scoreboard_on = 1'b0;
        held_rdata = 32'h0;
        model_passed = 1'b0;
        mem_valid = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_wstrb = 4'h0;
        reset = 1'b1;
        #1;
        dut.sram[0] = 32'hDEADBEEF; model_mem[0] = 32'hDEADBEEF;
        dut.sram[1] = 32'hAABBCCDD; model_mem[1] = 32'hAABBCCDD;
        dut.sram[2] = 32'h2222_2222; model_mem[2] = 32'h2222_2222;
        dut.sram[3] = 32'h3333_3333; model_mem[3] = 32'h3333_3333;
        dut.sram[MEM_WORDS-1] = 32'hFFFF_0000; model_mem[MEM_WORDS-1] = 32'hFFFF_0000;
        repeat (3) @(negedge clock);
        check("reset_ready", {31'h0, mem_ready}, 32'h0);
        check("reset_rdata", mem_rdata, 32'h0);
        check("reset_passed", {31'h0, tests_passed}, 32'h0);
        reset = 1'b0;
        scoreboard_on = 1'b1;
        @(negedge clock);

        // Preloaded read
        do_req(32'h0, 32'h0, 4'b0000, rd);
        check("lit_read0", rd, 32'hDEADBEEF);

        // Byte-strobed write then readback
        do_req(32'h4, 32'h11223344, 4'b0101, rd);
        do_req(32'h4, 32'h0, 4'b0000, rd);
        check("lit_strobe", rd, 32'hAA22CC44);

        // Table of writes/reads incl. the last in-range word
        foreach (vecs[i]) do_req(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, rd);
        do_req(32'h8, 32'h0, 4'b0000, rd);
        check("lit_byte3", rd, 32'h12FE_F00D);
        do_req(32'h0001_FFFC, 32'h0, 4'b0000, rd);
        check("lit_last_word", rd, 32'hFFFF_C0DE);

        // Pass flag: set, sticky against other values
        do_req(PASS_A, PASS_V, 4'b1111, rd);
        check("lit_pass_set", {31'h0, tests_passed}, 32'h1);
        do_req(PASS_A, 32'h0, 4'b1111, rd);
        check("lit_pass_sticky", {31'h0, tests_passed}, 32'h1);

        // Just past the end: reads 0, write must not alias onto word 0
        do_req(32'h0002_0000, 32'h0, 4'b0000, rd);
        check("lit_oob_read", rd, 32'h0);
        do_req(32'h0002_0000, 32'h5A5A_5A5A, 4'b1111, rd);
        do_req(32'h8000_0004, 32'h5A5A_5A5A, 4'b1111, rd);
        do_req(32'h0, 32'h0, 4'b0000, rd);
        check("lit_no_wrap", rd, 32'hDEADBEEF);

        // Console character and an ignored high address
        do_req(CONS_A, 32'h0000_0041, 4'b0001, rd);
        $write("\n");
        do_req(32'h3000_0000, 32'h0, 4'b0000, rd);
        check("lit_unmapped_read", rd, 32'h0);

        // Held mem_valid: completions every second cycle
        exp_q.push_back('{1'b0, model_read(32'h4)});
        exp_q.push_back('{1'b0, model_read(32'h4)});
        mem_valid = 1'b1; mem_addr = 32'h4; mem_wstrb = 4'b0; mem_wdata = 32'h0;
        @(posedge clock); #1; check("b2b_ready0", {31'h0, mem_ready}, 32'h1);
        @(posedge clock); #1; check("b2b_ready1", {31'h0, mem_ready}, 32'h0);
        @(posedge clock); #1; check("b2b_ready2", {31'h0, mem_ready}, 32'h1);
        @(negedge clock); mem_valid = 1'b0;
        @(posedge clock); #1; check("b2b_ready3", {31'h0, mem_ready}, 32'h0);
        @(negedge clock);

        // Cancelled request: valid dropped before an edge does nothing
        mem_valid = 1'b1; mem_addr = 32'hC; mem_wdata = 32'h9999_9999; mem_wstrb = 4'hF;
        #2 mem_valid = 1'b0;
        @(posedge clock); #1; check("cancel_no_ready", {31'h0, mem_ready}, 32'h0);
        @(negedge clock);
        do_req(32'hC, 32'h0, 4'b0000, rd);
        check("lit_cancel_intact", rd, 32'h3333_3333);

        // Reset while a read completes: outputs drop at once
        mem_valid = 1'b1; mem_addr = 32'h4; mem_wstrb = 4'b0;
        @(posedge clock); #1;
        check("pre_reset_ready", {31'h0, mem_ready}, 32'h1);
        check("pre_reset_rdata", mem_rdata, 32'hAA22CC44);
        reset = 1'b1;
        model_passed = 1'b0;
        #1;
        check("async_ready", {31'h0, mem_ready}, 32'h0);
        check("async_rdata", mem_rdata, 32'h0);
        check("async_passed", {31'h0, tests_passed}, 32'h0);
        // A write held across reset must be dropped
        mem_addr = 32'hC; mem_wdata = 32'h5555_5555; mem_wstrb = 4'hF;
        repeat (3) @(negedge clock);
        mem_valid = 1'b0;
        reset = 1'b0;
        exp_q.delete();
        held_rdata = 32'h0;
        @(negedge clock);
        do_req(32'hC, 32'h0, 4'b0000, rd);
        check("lit_reset_dropped", rd, 32'h3333_3333);
        do_req(32'h0, 32'h0, 4'b0000, rd);
        check("lit_sram_survives", rd, 32'hDEADBEEF);
        do_req(32'h4, 32'h0, 4'b0000, rd);

        // Pass flag works again after a fresh reset
        do_reset();
        @(negedge clock);
        do_req(PASS_A + 32'd2, PASS_V, 4'b1111, rd);
        check("lit_pass_again", {31'h0, tests_passed}, 32'h1);

        repeat (2) @(negedge clock);
        check("exp_q_drained", 32'(exp_q.size()), 32'h0);
        scoreboard_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Time limit guard
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish by %0t", $time);
        $fatal(1);
    end

endmodule
